// File: rtl/dma_bus_arbiter_pkg.sv
// Shared constants, state encoding and address helper for the DMA bus arbiter.
package dma_bus_arbiter_pkg;

    // Default CPU-visible trigger register and fixed DMA destination port.
    localparam logic [15:0] DEF_DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] DEF_DEST_ADDR    = 16'h2004;
    localparam int          DEF_LEN          = 256;

    // Arbiter states: IDLE hands the bus to the proc, RD/WR alternate per byte,
    // RESTORE re-presents the proc address so its read data is valid on resume.
    typedef enum logic [1:0] {
        DMA_IDLE    = 2'd0,
        DMA_RD      = 2'd1,
        DMA_WR      = 2'd2,
        DMA_RESTORE = 2'd3
    } dma_state_e;

    // Source byte address: page base plus byte index, 16-bit wrapping add.
    function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [8:0] idx);
        return {page, 8'h00} + {7'd0, idx};
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Bundles the proc-side and RAM-side bus signals around the arbiter.
// slave  : the arbiter's view (drives cpu_rd_data/cpu_rdy and the mem_* bus).
// master : the environment's view (proc drives cpu_*, RAM drives mem_rd_data).
interface dma_bus_arbiter_if;

    logic [15:0] cpu_address;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_enable;
    logic [7:0]  cpu_rd_data;
    logic        cpu_rdy;

    logic [15:0] mem_address;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_enable;
    logic [7:0]  mem_rd_data;

    modport slave (
        input  cpu_address,
        input  cpu_wr_data,
        input  cpu_wr_enable,
        output cpu_rd_data,
        output cpu_rdy,
        output mem_address,
        output mem_wr_data,
        output mem_wr_enable,
        input  mem_rd_data
    );

    modport master (
        output cpu_address,
        output cpu_wr_data,
        output cpu_wr_enable,
        input  cpu_rd_data,
        input  cpu_rdy,
        input  mem_address,
        input  mem_wr_data,
        input  mem_wr_enable,
        output mem_rd_data
    );

endinterface

// File: rtl/dma_bus_arbiter.sv
// Single-port memory bus owner: passes proc cycles through, and on a write to
// the trigger register stalls the proc and copies LEN bytes from page
// {data,8'h00} to a fixed destination port, one read/write pair per byte.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DEF_DMA_REG_ADDR,
    parameter logic [15:0] DEST_ADDR    = DEF_DEST_ADDR,
    parameter int          LEN          = DEF_LEN   // legal range 1..256
) (
    input  logic               clk,
    input  logic               resetn,
    dma_bus_arbiter_if.slave   bus
);

    // Index of the final byte; the WR of this index moves on to RESTORE.
    localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q,  page_d;
    logic [8:0]  idx_q,   idx_d;

    // Read data always goes straight back; only meaningful to the proc in IDLE.
    assign bus.cpu_rd_data = bus.mem_rd_data;
    assign bus.cpu_rdy     = (state_q == DMA_IDLE);

    // Next-state logic and memory-bus mux (proc pass-through unless DMA owns it).
    always_comb begin
        state_d           = state_q;
        page_d            = page_q;
        idx_d             = idx_q;
        bus.mem_address   = bus.cpu_address;
        bus.mem_wr_data   = bus.cpu_wr_data;
        bus.mem_wr_enable = bus.cpu_wr_enable;

        case (state_q)
            DMA_IDLE: begin
                // The trigger register is not backed by RAM: swallow the
                // write and latch the source page instead.
                if (bus.cpu_wr_enable && (bus.cpu_address == DMA_REG_ADDR)) begin
                    bus.mem_wr_enable = 1'b0;
                    page_d            = bus.cpu_wr_data;
                    idx_d             = 9'd0;
                    state_d           = DMA_RD;
                end
            end
            DMA_RD: begin
                bus.mem_address   = src_addr(page_q, idx_q);
                bus.mem_wr_enable = 1'b0;
                state_d           = DMA_WR;
            end
            DMA_WR: begin
                // RAM returns the byte addressed in RD during this cycle.
                bus.mem_address   = DEST_ADDR;
                bus.mem_wr_data   = bus.mem_rd_data;
                bus.mem_wr_enable = 1'b1;
                idx_d             = idx_q + 9'd1;
                state_d           = (idx_q == LAST_IDX) ? DMA_RESTORE : DMA_RD;
            end
            DMA_RESTORE: begin
                // Re-present the held proc address so read data is fresh on resume.
                bus.mem_wr_enable = 1'b0;
                state_d           = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // State, page and byte-index registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DMA_IDLE;
            page_q  <= 8'd0;
            idx_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a 256-byte instance and a 1-byte instance,
// each with its own registered-read RAM model.
module tb_dma_bus_arbiter;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    dma_bus_arbiter_if bus0 ();
    dma_bus_arbiter_if bus1 ();

    dma_bus_arbiter #(.LEN(256)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    dma_bus_arbiter #(.LEN(1)) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    logic [7:0] ram0 [65536];
    logic [7:0] ram1 [65536];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic       wr4014 = 1'b0;

    int checks = 0;
    int errors = 0;

    // RAM models: data valid the cycle after the address is presented.
    always @(posedge clk) begin
        bus0.mem_rd_data <= ram0[bus0.mem_address];
        if (bus0.mem_wr_enable) ram0[bus0.mem_address] = bus0.mem_wr_data;
        bus1.mem_rd_data <= ram1[bus1.mem_address];
        if (bus1.mem_wr_enable) ram1[bus1.mem_address] = bus1.mem_wr_data;
    end

    // Record every byte written to the destination port and any trigger-reg write.
    always @(posedge clk) begin
        if (bus0.mem_wr_enable && bus0.mem_address == 16'h2004) q0.push_back(bus0.mem_wr_data);
        if (bus1.mem_wr_enable && bus1.mem_address == 16'h2004) q1.push_back(bus1.mem_wr_data);
        if ((bus0.mem_wr_enable && bus0.mem_address == 16'h4014) ||
            (bus1.mem_wr_enable && bus1.mem_address == 16'h4014)) wr4014 = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int bad;

        resetn             = 1'b0;
        bus0.cpu_address   = 16'h0000;
        bus0.cpu_wr_data   = 8'h00;
        bus0.cpu_wr_enable = 1'b0;
        bus1.cpu_address   = 16'h0000;
        bus1.cpu_wr_data   = 8'h00;
        bus1.cpu_wr_enable = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            ram0[i] = 8'h00;
            ram1[i] = 8'h00;
        end
        for (int i = 0; i < 256; i++) begin
            ram0[16'h0300 + i] = 8'(i) ^ 8'hA5;
            ram0[16'h0400 + i] = 8'(i) ^ 8'h3C;
        end
        ram0[16'h0010] = 8'h77;
        ram1[16'hFF00] = 8'hC3;

        // Reset state
        tick();
        tick();
        chk("reset_rdy", bus0.cpu_rdy, 1);
        chk("reset_rdy_len1", bus1.cpu_rdy, 1);
        resetn = 1'b1;

        // 1: pass-through write then read-back
        bus0.cpu_address   = 16'h0200;
        bus0.cpu_wr_data   = 8'h5A;
        bus0.cpu_wr_enable = 1'b1;
        #1;
        chk("pt_addr", bus0.mem_address, 16'h0200);
        chk("pt_data", bus0.mem_wr_data, 8'h5A);
        chk("pt_we", bus0.mem_wr_enable, 1);
        chk("pt_rdy", bus0.cpu_rdy, 1);
        tick();
        bus0.cpu_wr_enable = 1'b0;
        #1;
        chk("pt_rd_we", bus0.mem_wr_enable, 0);
        tick();
        chk("pt_readback", bus0.cpu_rd_data, 8'h5A);
        chk("pt_rdy_after", bus0.cpu_rdy, 1);

        // 2/3: full DMA from page 03 with a held proc read of 0x0010
        q0.delete();
        bus0.cpu_address   = 16'h4014;
        bus0.cpu_wr_data   = 8'h03;
        bus0.cpu_wr_enable = 1'b1;
        #1;
        chk("trig_we_blocked", bus0.mem_wr_enable, 0);
        chk("trig_rdy", bus0.cpu_rdy, 1);
        tick();
        bus0.cpu_address   = 16'h0010;
        bus0.cpu_wr_data   = 8'h00;
        bus0.cpu_wr_enable = 1'b0;
        #1;
        chk("rd_addr", bus0.mem_address, 16'h0300);
        chk("rd_we", bus0.mem_wr_enable, 0);
        chk("rd_rdy", bus0.cpu_rdy, 0);
        n = 0;
        tick();
        n++;
        chk("wr_addr", bus0.mem_address, 16'h2004);
        chk("wr_we", bus0.mem_wr_enable, 1);
        chk("wr_data0", bus0.mem_wr_data, 8'hA5);
        while (bus0.cpu_rdy !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("dma1_stall", n, 513);
        chk("resume_rd_data", bus0.cpu_rd_data, 8'h77);
        chk("dma1_count", q0.size(), 256);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (i >= q0.size() || q0[i] !== (8'(i) ^ 8'hA5)) bad++;
        chk("dma1_data_bad", bad, 0);

        // 6: back-to-back trigger (page 04) in the first IDLE cycle
        bus0.cpu_address   = 16'h4014;
        bus0.cpu_wr_data   = 8'h04;
        bus0.cpu_wr_enable = 1'b1;
        #1;
        chk("b2b_we_blocked", bus0.mem_wr_enable, 0);
        tick();
        bus0.cpu_address   = 16'h0010;
        bus0.cpu_wr_data   = 8'h00;
        bus0.cpu_wr_enable = 1'b0;
        #1;
        chk("b2b_rdy_low", bus0.cpu_rdy, 0);
        n = 0;
        while (bus0.cpu_rdy !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("dma2_stall", n, 513);
        chk("dma2_count", q0.size(), 512);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (256 + i >= q0.size() || q0[256 + i] !== (8'(i) ^ 8'h3C)) bad++;
        chk("dma2_data_bad", bad, 0);

        // 4: reset during the RD of idx 100
        tick();
        q0.delete();
        bus0.cpu_address   = 16'h4014;
        bus0.cpu_wr_data   = 8'h03;
        bus0.cpu_wr_enable = 1'b1;
        tick();
        bus0.cpu_address   = 16'h0010;
        bus0.cpu_wr_data   = 8'h00;
        bus0.cpu_wr_enable = 1'b0;
        repeat (200) tick();
        chk("rst_pre_writes", q0.size(), 100);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        chk("rst_rdy", bus0.cpu_rdy, 1);
        chk("rst_passthru", bus0.mem_address, 16'h0010);
        repeat (600) tick();
        chk("rst_no_more_writes", q0.size(), 100);
        chk("rst_rdy_later", bus0.cpu_rdy, 1);

        // 5: LEN=1 instance, page FF
        q1.delete();
        bus1.cpu_address   = 16'h4014;
        bus1.cpu_wr_data   = 8'hFF;
        bus1.cpu_wr_enable = 1'b1;
        tick();
        bus1.cpu_address   = 16'h0010;
        bus1.cpu_wr_data   = 8'h00;
        bus1.cpu_wr_enable = 1'b0;
        #1;
        chk("len1_src_addr", bus1.mem_address, 16'hFF00);
        n = 0;
        while (bus1.cpu_rdy !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("len1_stall", n, 3);
        chk("len1_count", q1.size(), 1);
        chk("len1_data", (q1.size() == 1) ? q1[0] : 8'hxx, 8'hC3);

        chk("no_4014_write", wr4014, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
